// File: rtl/rf_arb_pkg.sv
// Purpose: shared constants and helpers for the register-file writeback arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_arb_pkg;

   // Default register data and address widths.
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   // R0 is hardwired to zero, so writes to it are dropped and never
   // reported as hazards.
   localparam int R0_ADDR = 0;

   // Width of the round-robin pointer. It is kept at least one bit wide so
   // the pointer remains a legal vector for any requester count.
   function automatic int rr_ptr_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Purpose: combinational round-robin picker. It scans req starting at ptr and wraps.
// Latency: 0 cycles (purely combinational).
// Backpressure: none. The caller decides when the grant is consumed.
//
// Ports:
//   req        in   N     request vector
//   ptr        in   PW    highest-priority index for this cycle
//   grant      out  N     one-hot grant, all zero when req == 0
//   grant_idx  out  PW    encoded index of the granted bit (0 when none)
//   grant_vld  out  1     any bit granted
module rf_rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          grant_vld
);

   int idx;

   // The scan starts at ptr. The first requester found wins, and later
   // candidates are masked by grant_vld.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_vld && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            grant_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register file's single write port among NUM_REQ writeback requesters.
// Latency: an accepted write reaches wr_en one edge later if uncontended. The RF commits it at the edge after that.
// Backpressure: one-entry holding buffer per requester. req_ready drops while the buffer is
//               full and not being granted this cycle.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   req_valid/req_ready         per-requester handshake
//   req_addr/req_data           flattened. Requester i sits at [i*W +: W]
//   wr_en/wr_addr/wr_data       registered register-file write port
//   chk_addr_a/b, chk_hit_a/b   combinational in-flight write check for issue stalls
//   stall_cnt                   per-requester 32-bit stall counters (flattened)
//
// Config: define RF_ARB_STATS_EN to build the stall counters. Without it, stall_cnt is tied to 0.
module regfile_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_REQ    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic                           wr_en,
   output logic [ADDR_WIDTH-1:0]          wr_addr,
   output logic [DATA_WIDTH-1:0]          wr_data,
   input  logic [ADDR_WIDTH-1:0]          chk_addr_a,
   input  logic [ADDR_WIDTH-1:0]          chk_addr_b,
   output logic                           chk_hit_a,
   output logic                           chk_hit_b,
   output logic [NUM_REQ*32-1:0]          stall_cnt
);

   localparam int                    PTR_W     = rr_ptr_width(NUM_REQ);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(R0_ADDR);
   localparam logic [PTR_W-1:0]      LAST_IDX  = PTR_W'(NUM_REQ - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

   logic [NUM_REQ-1:0] hold_valid;
   wb_entry_t          hold [NUM_REQ];
   logic [PTR_W-1:0]   rr_ptr;

   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_vld;

   logic [NUM_REQ-1:0] accept;
   logic [NUM_REQ-1:0] addr_nz;
   logic               pend_a;
   logic               pend_b;

   // The grant sees only buffered entries. This keeps req_valid out of the
   // ready path, so there is no combinational loop through a requester.
   rf_rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_rr_arb (
      .req       (hold_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // A buffer that drains this cycle can be refilled in the same cycle.
   // This gives one write per cycle per requester.
   assign req_ready = {NUM_REQ{rst_n}} & (~hold_valid | grant);

   always_comb begin
      accept  = '0;
      addr_nz = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         accept[i]  = req_valid[i] & req_ready[i];
         addr_nz[i] = (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_ADDR);
      end
   end

   // Control state: holding-buffer valid bits, the round-robin pointer and the write stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_valid <= '0;
         rr_ptr     <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         if (grant_vld) begin
            wr_en   <= 1'b1;
            wr_addr <= hold[grant_idx].addr;
            wr_data <= hold[grant_idx].data;
            rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
         end else begin
            wr_en <= 1'b0;
         end
         // An accept overrides the grant's clear. An R0 accept empties the slot.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
               hold_valid[i] <= addr_nz[i];
            end else if (grant[i]) begin
               hold_valid[i] <= 1'b0;
            end
         end
      end
   end

   // The payload needs no reset because hold_valid qualifies every use of it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i] && addr_nz[i]) begin
            hold[i].addr <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hold[i].data <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A write is in flight while it sits in a buffer or in the write stage.
   // wr_addr keeps its old value when wr_en is low, so wr_en must gate it.
   always_comb begin
      pend_a = wr_en && (wr_addr == chk_addr_a);
      pend_b = wr_en && (wr_addr == chk_addr_b);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hold_valid[i] && (hold[i].addr == chk_addr_a)) pend_a = 1'b1;
         if (hold_valid[i] && (hold[i].addr == chk_addr_b)) pend_b = 1'b1;
      end
   end

   assign chk_hit_a = (chk_addr_a != ZERO_ADDR) && pend_a;
   assign chk_hit_b = (chk_addr_b != ZERO_ADDR) && pend_b;

`ifdef RF_ARB_STATS_EN
   // Counts cycles where a requester presents a write and is refused. Wraps at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
               stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
            end
         end
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: scoreboard bench for regfile_wb_arbiter. Expected writes are queued when driven and popped when wr_en fires.
// Latency: inputs change on the falling edge and outputs are sampled on the falling edge, away from the posedge.
// Backpressure: each request is recorded as accepted only when req_ready is high at the drive point.
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [AW-1:0]    chk_addr_a;
   logic [AW-1:0]    chk_addr_b;
   logic             chk_hit_a;
   logic             chk_hit_b;
   logic [NR*32-1:0] stall_cnt;

   int  n_cmp = 0;
   int  n_bad = 0;
   wr_t sb [$];
   wr_t sb1 [$];

   regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .chk_addr_a (chk_addr_a),
      .chk_addr_b (chk_addr_b),
      .chk_hit_a  (chk_hit_a),
      .chk_hit_b  (chk_hit_b),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_req(input int r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[r]         = v;
      req_addr[r*AW +: AW] = a;
      req_data[r*DW +: DW] = d;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      req_addr   = {5'd4, 5'd3, 5'd2, 5'd1};
      req_data   = {32'h44, 32'h33, 32'h22, 32'h11};
      chk_addr_a = '0;
      chk_addr_b = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (req_ready !== 4'b0000 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
            n_bad++;
            $display("FAIL reset_hold cyc%0d: ready=%b wr_en=%b addr=%0d data=%h, want 0/0/0/0", c, req_ready, wr_en, wr_addr, wr_data);
         end
      end
      rst_n     = 1'b1;
      req_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b1111) begin
         n_bad++;
         $display("FAIL reset_release: ready=%b want 1111", req_ready);
      end
   endtask

   task automatic test_stream();
      int  sent = 0, got = 0, first_drv = -1, first_wr = -1, last_wr = -1;
      wr_t e;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (wr_en) begin
            if (first_wr < 0) first_wr = c;
            last_wr = c;
            got++;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL stream_unexpected: addr=%0d data=%h with empty scoreboard", wr_addr, wr_data);
            end else begin
               e = sb.pop_front();
               if ({wr_addr, wr_data} !== e) begin
                  n_bad++;
                  $display("FAIL stream_write: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
         if (sent < 8) begin
            n_cmp++;
            if (req_ready[0] !== 1'b1) begin
               n_bad++;
               $display("FAIL stream_ready n=%0d: ready0=%b want 1", sent + 1, req_ready[0]);
            end
            if (first_drv < 0) first_drv = c;
            drive_req(0, 1'b1, AW'(sent + 1), 32'h100 + 32'(sent + 1));
            e.addr = AW'(sent + 1);
            e.data = 32'h100 + 32'(sent + 1);
            sb.push_back(e);
            sent++;
         end else begin
            drive_req(0, 1'b0, '0, '0);
         end
      end
      n_cmp++;
      if (got != 8 || first_wr != first_drv + 2 || last_wr - first_wr != 7 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL stream_timing: got=%0d first=%0d last=%0d left=%0d want 8/%0d/%0d/0", got, first_wr, last_wr, sb.size(), first_drv + 2, first_drv + 9);
      end
      sb.delete();
   endtask

   task automatic test_contention();
      int  got = 0, first_wr = -1, last_wr = -1;
      wr_t e;
      reset_pulse();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (wr_en) begin
            if (first_wr < 0) first_wr = c;
            last_wr = c;
            got++;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL contend_unexpected: addr=%0d", wr_addr);
            end else begin
               e = sb.pop_front();
               if ({wr_addr, wr_data} !== e) begin
                  n_bad++;
                  $display("FAIL contend_order: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
         if (c == 0) begin
            n_cmp++;
            if (req_ready !== 4'b1111) begin
               n_bad++;
               $display("FAIL contend_ready: ready=%b want 1111", req_ready);
            end
            for (int r = 0; r < NR; r++) begin
               drive_req(r, 1'b1, AW'(5 + r), 32'hC0DE_0000 + 32'(r));
               e.addr = AW'(5 + r);
               e.data = 32'hC0DE_0000 + 32'(r);
               sb.push_back(e);
            end
         end else begin
            req_valid = '0;
         end
      end
      n_cmp++;
      if (got != 4 || first_wr != 2 || last_wr != 5 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL contend_timing: got=%0d first=%0d last=%0d left=%0d want 4/2/5/0", got, first_wr, last_wr, sb.size());
      end
      n_cmp++;
      if (dut.rr_ptr !== 2'd0) begin
         n_bad++;
         $display("FAIL contend_rr_ptr: got %0d want 0", dut.rr_ptr);
      end
      sb.delete();
   endtask

   task automatic test_r0_drop();
      chk_addr_a = '0;
      chk_addr_b = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (wr_en !== 1'b0 || chk_hit_a !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_drop cyc%0d: wr_en=%b hit_a=%b want 0/0", c, wr_en, chk_hit_a);
         end
         if (c < 2) begin
            n_cmp++;
            if (req_ready[2] !== 1'b1) begin
               n_bad++;
               $display("FAIL r0_ready cyc%0d: ready2=%b want 1", c, req_ready[2]);
            end
         end
         if (c == 0) drive_req(2, 1'b1, '0, 32'hDEAD_BEEF);
         else        req_valid = '0;
      end
   endtask

   task automatic test_hazard();
      logic exp_hit [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      wr_t  e;
      chk_addr_a = 5'd9;
      chk_addr_b = 5'd10;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (chk_hit_a !== exp_hit[c] || chk_hit_b !== 1'b0) begin
            n_bad++;
            $display("FAIL hazard_hit cyc%0d: hit_a=%b hit_b=%b want %b/0", c, chk_hit_a, chk_hit_b, exp_hit[c]);
         end
         n_cmp++;
         if (wr_en !== (c == 2)) begin
            n_bad++;
            $display("FAIL hazard_wr_en cyc%0d: wr_en=%b want %b", c, wr_en, (c == 2));
         end else if (wr_en) begin
            e = sb.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               n_bad++;
               $display("FAIL hazard_write: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
            end
         end
         if (c == 0) begin
            drive_req(1, 1'b1, 5'd9, 32'h0000_0909);
            e.addr = 5'd9;
            e.data = 32'h0000_0909;
            sb.push_back(e);
         end else begin
            req_valid = '0;
         end
      end
      sb.delete();
   endtask

   task automatic test_back_to_back();
      int          sent0 = 0, sent1 = 0, got = 0, stalls0 = 0, stalls1 = 0;
      logic [31:0] exp0, exp1;
      wr_t         e;
      reset_pulse();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr_en) begin
            got++;
            n_cmp++;
            if (wr_addr >= 5'd10 && wr_addr <= 5'd12 && sb.size() != 0) begin
               e = sb.pop_front();
            end else if (wr_addr >= 5'd20 && wr_addr <= 5'd22 && sb1.size() != 0) begin
               e = sb1.pop_front();
            end else begin
               e = '0;
            end
            if ({wr_addr, wr_data} !== e) begin
               n_bad++;
               $display("FAIL b2b_write: got %0d/%h want %0d/%h", wr_addr, wr_data, e.addr, e.data);
            end
         end
         if (sent0 < 3) begin
            drive_req(0, 1'b1, AW'(10 + sent0), 32'hA0 + 32'(sent0));
            if (req_ready[0]) begin
               e.addr = AW'(10 + sent0);
               e.data = 32'hA0 + 32'(sent0);
               sb.push_back(e);
               sent0++;
            end else stalls0++;
         end else drive_req(0, 1'b0, '0, '0);
         if (sent1 < 3) begin
            drive_req(1, 1'b1, AW'(20 + sent1), 32'hB0 + 32'(sent1));
            if (req_ready[1]) begin
               e.addr = AW'(20 + sent1);
               e.data = 32'hB0 + 32'(sent1);
               sb1.push_back(e);
               sent1++;
            end else stalls1++;
         end else drive_req(1, 1'b0, '0, '0);
      end
      n_cmp++;
      if (got != 6 || sb.size() != 0 || sb1.size() != 0) begin
         n_bad++;
         $display("FAIL b2b_drain: got=%0d left0=%0d left1=%0d want 6/0/0", got, sb.size(), sb1.size());
      end
`ifdef RF_ARB_STATS_EN
      exp0 = 32'(stalls0);
      exp1 = 32'(stalls1);
`else
      exp0 = 32'd0;
      exp1 = 32'd0;
`endif
      n_cmp++;
      if (stall_cnt !== {32'd0, 32'd0, exp1, exp0}) begin
         n_bad++;
         $display("FAIL b2b_stall_cnt: got %h want %h", stall_cnt, {32'd0, 32'd0, exp1, exp0});
      end
      sb.delete();
      sb1.delete();
   endtask

   task automatic test_mid_reset();
      chk_addr_a = '0;
      chk_addr_b = 5'd3;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         n_cmp++;
         if (wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_wr_en cyc%0d: wr_en=%b addr=%0d want 0", c, wr_en, wr_addr);
         end
         if (c == 0) begin
            n_cmp++;
            if (req_ready[3] !== 1'b1) begin
               n_bad++;
               $display("FAIL midrst_ready: ready3=%b want 1", req_ready[3]);
            end
            drive_req(3, 1'b1, 5'd3, 32'h3333_3333);
         end else if (c == 1) begin
            n_cmp++;
            if (chk_hit_b !== 1'b1) begin
               n_bad++;
               $display("FAIL midrst_held: hit_b=%b want 1", chk_hit_b);
            end
            req_valid = '0;
            rst_n     = 1'b0;
         end else if (c == 2) begin
            n_cmp++;
            if (chk_hit_b !== 1'b0 || stall_cnt !== '0 || req_ready !== 4'b0000) begin
               n_bad++;
               $display("FAIL midrst_cleared: hit_b=%b stall=%h ready=%b want 0/0/0000", chk_hit_b, stall_cnt, req_ready);
            end
            rst_n = 1'b1;
         end else if (c == 3) begin
            n_cmp++;
            if (req_ready !== 4'b1111) begin
               n_bad++;
               $display("FAIL midrst_release: ready=%b want 1111", req_ready);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_contention();
      test_r0_drop();
      test_hazard();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
